// File: rtl/mul_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_rr_arbiter
// Description : Shares one pipelined signed multiplier among N requesters.
//               Each cycle it grants one valid requester in round-robin order.
//               The requester ID travels through a tag pipeline that matches
//               the multiplier latency. Each product is then steered back to
//               the requester that issued it.
// Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH    operand width (even, matches the multiplier instance)
//   N        number of requesters (N >= 2)
//   MUL_LAT  multiplier latency from mul_din_valid to mul_dout_valid
//   ID_W     requester tag width, $clog2(N)
// Ports
//   clk, nrst            clock, asynchronous active-low reset
//   en                   issue enable (0 stops new grants, in-flight drains)
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_din1/req_din2    flat operands, requester i at [i*WIDTH +: WIDTH]
//   mul_din1/2, mul_din_valid   registered issue to the multiplier
//   mul_dout, mul_dout_valid    product returned by the multiplier
//   rsp_valid, rsp_dout  registered one-hot response strobe and product
//   busy                 work held in the issue register or the tag pipeline
//   err                  sticky mismatch between product strobe and tag
//   stat_cnt             per-requester saturating 16-bit issue counters
// Build option
//   MUL_ARB_STATS_EN     when defined, build the stat_cnt counters.
//                        When undefined, stat_cnt is tied to zero.
// ============================================================================
module mul_rr_arbiter #(
    parameter int WIDTH   = 26,
    parameter int N       = 4,
    parameter int MUL_LAT = 14,
    parameter int ID_W    = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 en,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*WIDTH-1:0]   req_din1,
    input  logic [N*WIDTH-1:0]   req_din2,
    output logic [WIDTH-1:0]     mul_din1,
    output logic [WIDTH-1:0]     mul_din2,
    output logic                 mul_din_valid,
    input  logic [2*WIDTH-1:0]   mul_dout,
    input  logic                 mul_dout_valid,
    output logic [N-1:0]         rsp_valid,
    output logic [2*WIDTH-1:0]   rsp_dout,
    output logic                 busy,
    output logic                 err,
    output logic [N*16-1:0]      stat_cnt
);

    // ------------------------------------------------------------------
    // Round-robin winner selection
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    last_q;
    logic [ID_W-1:0]    winner;
    logic [ID_W-1:0]    cand;
    logic               found;
    logic               accept;

    // The search begins one position past the last grant and wraps modulo N.
    // The last grant itself is examined last, so a lone requester can win
    // every cycle.
    always_comb begin
        winner = last_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N; k++) begin
            cand = ID_W'((int'(last_q) + k) % N);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign accept = en & found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Operand mux for the granted requester
    logic [WIDTH-1:0]   din1_sel;
    logic [WIDTH-1:0]   din2_sel;

    always_comb begin
        din1_sel = '0;
        din2_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == ID_W'(i)) begin
                din1_sel = req_din1[i*WIDTH +: WIDTH];
                din2_sel = req_din2[i*WIDTH +: WIDTH];
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   din1_q;
    logic [WIDTH-1:0]   din2_q;
    logic               din_valid_q;
    logic [ID_W-1:0]    issue_id_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_q      <= ID_W'(N - 1);
            din1_q      <= '0;
            din2_q      <= '0;
            din_valid_q <= 1'b0;
            issue_id_q  <= '0;
        end else begin
            din_valid_q <= accept;
            if (accept) begin
                din1_q     <= din1_sel;
                din2_q     <= din2_sel;
                issue_id_q <= winner;
                last_q     <= winner;
            end
        end
    end

    assign mul_din1      = din1_q;
    assign mul_din2      = din2_q;
    assign mul_din_valid = din_valid_q;

    // ------------------------------------------------------------------
    // Tag pipeline.
    // It shifts every cycle, like the multiplier it shadows. Entry 0 is
    // loaded from the issue register, so the tail lines up with
    // mul_dout_valid.
    // ------------------------------------------------------------------
    logic [MUL_LAT-1:0] tag_v_q;
    logic [ID_W-1:0]    tag_id_q [MUL_LAT];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                tag_v_q[k]  <= 1'b0;
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q[0]  <= din_valid_q;
            tag_id_q[0] <= issue_id_q;
            for (int k = 1; k < MUL_LAT; k++) begin
                tag_v_q[k]  <= tag_v_q[k-1];
                tag_id_q[k] <= tag_id_q[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response steering and error detection
    // ------------------------------------------------------------------
    logic               tail_v;
    logic [ID_W-1:0]    tail_id;
    logic               rsp_hit;
    logic [N-1:0]       rsp_onehot;
    logic [N-1:0]       rsp_valid_q;
    logic [2*WIDTH-1:0] rsp_dout_q;
    logic               err_q;
    logic               err_d;

    assign tail_v  = tag_v_q[MUL_LAT-1];
    assign tail_id = tag_id_q[MUL_LAT-1];
    // A response needs both the product strobe and a live tag. A strobe
    // without a tag, or a tag without a strobe, is flagged and suppressed.
    assign rsp_hit = mul_dout_valid & tail_v;
    assign err_d   = err_q | (mul_dout_valid ^ tail_v);

    always_comb begin
        rsp_onehot          = '0;
        rsp_onehot[tail_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rsp_valid_q <= '0;
            rsp_dout_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= err_d;
            if (rsp_hit) begin
                rsp_valid_q <= rsp_onehot;
                rsp_dout_q  <= mul_dout;
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_dout  = rsp_dout_q;
    assign err       = err_q;
    assign busy      = din_valid_q | (|tag_v_q);

    // ------------------------------------------------------------------
    // Optional per-requester issue statistics
    // ------------------------------------------------------------------
`ifdef MUL_ARB_STATS_EN
    for (genvar gi = 0; gi < N; gi++) begin : g_stat
        logic [15:0] cnt_q;

        always_ff @(posedge clk or negedge nrst) begin
            if (!nrst) begin
                cnt_q <= '0;
            end else if (accept && (winner == ID_W'(gi)) && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end

        assign stat_cnt[gi*16 +: 16] = cnt_q;
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_rr_arbiter
// Description : Directed self-checking bench for mul_rr_arbiter.
//               It includes a behavioural fixed-latency signed multiplier.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mul_rr_arbiter;
    localparam int WIDTH   = 26;
    localparam int N       = 4;
    localparam int MUL_LAT = 14;
    localparam int PW      = 2 * WIDTH;
    localparam int RSP_LAT = MUL_LAT + 2;

    logic              clk = 1'b0;
    logic              nrst;
    logic              en;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*WIDTH-1:0] req_din1;
    logic [N*WIDTH-1:0] req_din2;
    logic [WIDTH-1:0]  mul_din1;
    logic [WIDTH-1:0]  mul_din2;
    logic              mul_din_valid;
    logic [PW-1:0]     mul_dout;
    logic              mul_dout_valid;
    logic [N-1:0]      rsp_valid;
    logic [PW-1:0]     rsp_dout;
    logic              busy;
    logic              err;
    logic [N*16-1:0]   stat_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    mul_rr_arbiter #(.WIDTH(WIDTH), .N(N), .MUL_LAT(MUL_LAT)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .en             (en),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_din1       (req_din1),
        .req_din2       (req_din2),
        .mul_din1       (mul_din1),
        .mul_din2       (mul_din2),
        .mul_din_valid  (mul_din_valid),
        .mul_dout       (mul_dout),
        .mul_dout_valid (mul_dout_valid),
        .rsp_valid      (rsp_valid),
        .rsp_dout       (rsp_dout),
        .busy           (busy),
        .err            (err),
        .stat_cnt       (stat_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural multiplier ----------------
    logic          pv [MUL_LAT];
    logic [PW-1:0] pd [MUL_LAT];
    logic          inject;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pv[k] <= 1'b0;
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= mul_din_valid;
            pd[0] <= {{WIDTH{mul_din1[WIDTH-1]}}, mul_din1} * {{WIDTH{mul_din2[WIDTH-1]}}, mul_din2};
            for (int k = 1; k < MUL_LAT; k++) begin
                pv[k] <= pv[k-1];
                pd[k] <= pd[k-1];
            end
        end
    end

    assign mul_dout       = pd[MUL_LAT-1];
    assign mul_dout_valid = pv[MUL_LAT-1] | inject;

    // ---------------- response monitor ----------------
    logic [N-1:0]  rsp_v_q [$];
    logic [PW-1:0] rsp_d_q [$];
    int            rsp_c_q [$];
    logic          stat_seen_nz = 1'b0;

    always @(negedge clk) begin
        if (nrst && rsp_valid != '0) begin
            rsp_v_q.push_back(rsp_valid);
            rsp_d_q.push_back(rsp_dout);
            rsp_c_q.push_back(cyc);
        end
        if (stat_cnt != '0) stat_seen_nz <= 1'b1;
    end

    // ---------------- helpers (stimulus only) ----------------
    function automatic logic [PW-1:0] prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        ea = {{WIDTH{a[WIDTH-1]}}, a};
        eb = {{WIDTH{b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    task automatic set_ops(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_din1[i*WIDTH +: WIDTH] = a;
        req_din2[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic clear_q;
        rsp_v_q.delete();
        rsp_d_q.delete();
        rsp_c_q.delete();
    endtask

    task automatic apply_reset;
        req_valid = '0;
        en        = 1'b1;
        inject    = 1'b0;
        nrst      = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        nrst      = 1'b0;
        en        = 1'b1;
        req_valid = 4'b1111;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL reset_ready got=%b exp=0001", req_ready);
        else n_pass++;
        n_checks++;
        if ({mul_din_valid, mul_din1, mul_din2} !== '0)
            $display("FAIL reset_issue got v=%b a=%h b=%h exp all 0", mul_din_valid, mul_din1, mul_din2);
        else n_pass++;
        n_checks++;
        if (rsp_valid !== '0 || rsp_dout !== '0)
            $display("FAIL reset_rsp got v=%b d=%h exp 0", rsp_valid, rsp_dout);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0 || stat_cnt !== '0)
            $display("FAIL reset_status got busy=%b err=%b stat=%h exp 0", busy, err, stat_cnt);
        else n_pass++;
        req_valid = '0;
        #1;
        n_checks++;
        if (req_ready !== 4'b0000) $display("FAIL reset_ready_idle got=%b exp=0000", req_ready);
        else n_pass++;
        nrst = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    task automatic test_single;
        int acc;
        clear_q();
        set_ops(0, 26'd3, 26'h3FF_FFFB);  // 3 * -5
        req_valid = 4'b0001;
        #1;
        acc = cyc;
        n_checks++;
        if (req_ready !== 4'b0001) $display("FAIL single_ready got=%b exp=0001", req_ready);
        else n_pass++;
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++;
        if (mul_din_valid !== 1'b1 || mul_din1 !== 26'd3 || mul_din2 !== 26'h3FF_FFFB || busy !== 1'b1)
            $display("FAIL single_issue got v=%b a=%h b=%h busy=%b exp v=1 a=0000003 b=3fffffb busy=1",
                     mul_din_valid, mul_din1, mul_din2, busy);
        else n_pass++;
        for (int w = 0; w < 40 && rsp_v_q.size() < 1; w++) @(negedge clk);
        #1;
        n_checks++;
        if (rsp_v_q.size() != 1) begin
            $display("FAIL single_timeout got=%0d responses exp=1", rsp_v_q.size());
        end else begin
            n_pass++;
            n_checks++;
            if (rsp_v_q[0] !== 4'b0001 || rsp_d_q[0] !== 52'hF_FFFF_FFFF_FFF1)
                $display("FAIL single_rsp got v=%b d=%h exp v=0001 d=ffffffffffff1", rsp_v_q[0], rsp_d_q[0]);
            else n_pass++;
            n_checks++;
            if (rsp_c_q[0] - acc != RSP_LAT)
                $display("FAIL single_latency got=%0d exp=%0d", rsp_c_q[0] - acc, RSP_LAT);
            else n_pass++;
        end
    endtask

    task automatic test_round_robin;
        int            first_acc;
        logic [N-1:0]  exp_v [8];
        logic [PW-1:0] exp_d [8];
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        int            id;
        apply_reset();
        first_acc = 0;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < N; i++) begin
                a = WIDTH'(k * 1000 + i + 1);
                if (i % 2 == 1) a = -a;
                b = -WIDTH'(k + 2 * i + 2);
                set_ops(i, a, b);
            end
            req_valid = 4'b1111;
            #1;
            if (k == 0) first_acc = cyc;
            id = k % N;
            exp_v[k] = 4'b0001 << id;
            a = WIDTH'(k * 1000 + id + 1);
            if (id % 2 == 1) a = -a;
            exp_d[k] = prod(a, -WIDTH'(k + 2 * id + 2));
            n_checks++;
            if (req_ready !== exp_v[k]) $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, exp_v[k]);
            else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
        for (int w = 0; w < 60 && rsp_v_q.size() < 8; w++) @(negedge clk);
        #1;
        n_checks++;
        if (rsp_v_q.size() != 8) begin
            $display("FAIL rr_timeout got=%0d responses exp=8", rsp_v_q.size());
        end else begin
            n_pass++;
            for (int j = 0; j < 8; j++) begin
                n_checks++;
                if (rsp_v_q[j] !== exp_v[j] || rsp_d_q[j] !== exp_d[j] || rsp_c_q[j] != first_acc + RSP_LAT + j)
                    $display("FAIL rr_rsp%0d got v=%b d=%h cyc=%0d exp v=%b d=%h cyc=%0d", j,
                             rsp_v_q[j], rsp_d_q[j], rsp_c_q[j], exp_v[j], exp_d[j], first_acc + RSP_LAT + j);
                else n_pass++;
            end
        end
        n_checks++;
        if (err !== 1'b0) $display("FAIL rr_err got=%b exp=0", err);
        else n_pass++;
    endtask

    task automatic test_alternate;
        logic [N-1:0] exp_r;
        apply_reset();
        for (int i = 0; i < N; i++) set_ops(i, WIDTH'(i + 7), WIDTH'(i + 11));
        for (int k = 0; k < 6; k++) begin
            req_valid = 4'b1010;
            #1;
            exp_r = (k % 2 == 0) ? 4'b0010 : 4'b1000;
            n_checks++;
            if (req_ready !== exp_r) $display("FAIL alt_grant%0d got=%b exp=%b", k, req_ready, exp_r);
            else n_pass++;
            @(negedge clk);
        end
        req_valid = '0;
        for (int w = 0; w < 60 && rsp_v_q.size() < 6; w++) @(negedge clk);
        #1;
        n_checks++;
        if (rsp_v_q.size() != 6) begin
            $display("FAIL alt_timeout got=%0d responses exp=6", rsp_v_q.size());
        end else begin
            n_pass++;
            for (int j = 0; j < 6; j++) begin
                exp_r = (j % 2 == 0) ? 4'b0010 : 4'b1000;
                n_checks++;
                if (rsp_v_q[j] !== exp_r || rsp_d_q[j] !== ((j % 2 == 0) ? 52'd96 : 52'd140))
                    $display("FAIL alt_rsp%0d got v=%b d=%0d exp v=%b d=%0d", j, rsp_v_q[j], rsp_d_q[j],
                             exp_r, (j % 2 == 0) ? 96 : 140);
                else n_pass++;
            end
        end
    endtask

    task automatic test_en_drain;
        int last_acc;
        int last_busy;
        int bad_ready;
        apply_reset();
        last_acc = 0;
        for (int i = 0; i < N; i++) set_ops(i, WIDTH'(-(i + 2)), WIDTH'(i * 5 + 3));
        for (int k = 0; k < 3; k++) begin
            req_valid = 4'b0111;
            #1;
            last_acc = cyc;
            n_checks++;
            if (req_ready !== (4'b0001 << k)) $display("FAIL drain_grant%0d got=%b exp=%b", k, req_ready, 4'b0001 << k);
            else n_pass++;
            @(negedge clk);
        end
        en        = 1'b0;
        req_valid = 4'b1111;
        last_busy = -1;
        bad_ready = 0;
        for (int w = 0; w < 20; w++) begin
            #1;
            if (req_ready !== '0) bad_ready++;
            if (busy === 1'b1) last_busy = cyc;
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (bad_ready != 0) $display("FAIL drain_ready got=%0d cycles with ready exp=0", bad_ready);
        else n_pass++;
        n_checks++;
        if (last_busy != last_acc + MUL_LAT + 1 || busy !== 1'b0)
            $display("FAIL drain_busy got last_busy_cyc=%0d busy=%b exp=%0d busy=0", last_busy, busy, last_acc + MUL_LAT + 1);
        else n_pass++;
        n_checks++;
        if (rsp_v_q.size() != 3) begin
            $display("FAIL drain_count got=%0d exp=3", rsp_v_q.size());
        end else begin
            n_pass++;
            for (int j = 0; j < 3; j++) begin
                n_checks++;
                if (rsp_v_q[j] !== (4'b0001 << j) || rsp_d_q[j] !== prod(WIDTH'(-(j + 2)), WIDTH'(j * 5 + 3)))
                    $display("FAIL drain_rsp%0d got v=%b d=%h exp v=%b d=%h", j, rsp_v_q[j], rsp_d_q[j],
                             4'b0001 << j, prod(WIDTH'(-(j + 2)), WIDTH'(j * 5 + 3)));
                else n_pass++;
            end
        end
        en        = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_spurious;
        apply_reset();
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b1 || rsp_valid !== '0)
            $display("FAIL spur_err got err=%b rsp_v=%b exp err=1 rsp_v=0000", err, rsp_valid);
        else n_pass++;
        repeat (5) @(negedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || rsp_v_q.size() != 0)
            $display("FAIL spur_sticky got err=%b rsps=%0d exp err=1 rsps=0", err, rsp_v_q.size());
        else n_pass++;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (err !== 1'b0) $display("FAIL spur_clear got=%b exp=0", err);
        else n_pass++;
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stats;
        int bad_ready;
        apply_reset();
        set_ops(2, 26'd9, 26'h3FF_FFFF);
        bad_ready = 0;
`ifdef MUL_ARB_STATS_EN
        for (int k = 0; k < 70000; k++) begin
            req_valid = 4'b0100;
            #1;
            if (req_ready !== 4'b0100) bad_ready++;
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        n_checks++;
        if (stat_cnt[32 +: 16] !== 16'hFFFF) $display("FAIL stat_sat got=%h exp=ffff", stat_cnt[32 +: 16]);
        else n_pass++;
        n_checks++;
        if (stat_cnt[0 +: 16] !== '0 || stat_cnt[16 +: 16] !== '0 || stat_cnt[48 +: 16] !== '0)
            $display("FAIL stat_others got=%h exp=0 in slots 0,1,3", stat_cnt);
        else n_pass++;
`else
        for (int k = 0; k < 6; k++) begin
            req_valid = 4'b0100;
            #1;
            if (req_ready !== 4'b0100) bad_ready++;
            @(negedge clk);
        end
        req_valid = '0;
        #1;
        n_checks++;
        if (stat_seen_nz !== 1'b0 || stat_cnt !== '0)
            $display("FAIL stat_zero got seen_nonzero=%b stat=%h exp 0", stat_seen_nz, stat_cnt);
        else n_pass++;
`endif
        n_checks++;
        if (bad_ready != 0) $display("FAIL single_hold got=%0d cycles without grant exp=0", bad_ready);
        else n_pass++;
        repeat (RSP_LAT + 2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || err !== 1'b0) $display("FAIL stat_end got busy=%b err=%b exp 0 0", busy, err);
        else n_pass++;
        clear_q();
    endtask

    initial begin
        nrst      = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_din1  = '0;
        req_din2  = '0;
        inject    = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_alternate();
        test_en_drain();
        test_spurious();
        test_stats();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mul_rr_arbiter.md
# mul_rr_arbiter

Shares one pipelined signed Booth multiplier (WIDTH-bit operands, 2·WIDTH-bit product, one issue per cycle, no back-pressure, fixed latency) among N requesters. Each cycle it grants the multiplier round-robin to one valid requester. It tags the issued operation with the requester ID in a shadow pipeline matched to the multiplier latency, and steers each product back to the requester that issued it. It sits between the DCT/quantiser clients and the shared multiplier instance.

## Interface
Parameters:
- WIDTH, 26 — operand width; even, matches the multiplier instance.
- N, 4 — number of requesters; N ≥ 2.
- MUL_LAT, 14 — multiplier latency from `mul_din_valid` to `mul_dout_valid`, in cycles (WIDTH/2 + 1).
- ID_W, $clog2(N) — tag width (derived).

Ports:
- clk  in  1  clock.
- nrst  in  1  reset, asynchronous, active-low.
- en  in  1  issue enable; 0 stops new grants, in-flight work drains.
- req_valid  in  N  per-requester operation valid.
- req_ready  out  N  per-requester accept (one-hot or zero).
- req_din1  in  N·WIDTH  flat operand A, requester i at [i·WIDTH +: WIDTH].
- req_din2  in  N·WIDTH  flat operand B, same packing.
- mul_din1, mul_din2  out  WIDTH  operands to the multiplier (registered).
- mul_din_valid  out  1  issue strobe to the multiplier (registered).
- mul_dout  in  2·WIDTH  product from the multiplier.
- mul_dout_valid  in  1  product strobe.
- rsp_valid  out  N  one-hot result strobe (registered).
- rsp_dout  out  2·WIDTH  product, shared by all requesters (registered).
- busy  out  1  any operation in the issue register or in the tag pipeline.
- err  out  1  sticky tag/strobe mismatch.
- stat_cnt  out  N·16  per-requester issue counters (see Configuration).

## Operation
- Round-robin pointer `last` (ID_W bits) holds the last granted ID. The search starts at last+1 mod N; the first i with req_valid[i] wins.
- req_ready[i] is combinational: en & (i == winner) & at least one req_valid. Requesters are not allowed to depend on req_ready to drive req_valid.
- Accept = req_valid[i] & req_ready[i]. On accept:
  - The operands of i are registered into mul_din1/2, and mul_din_valid is 1 on the next cycle.
  - `last` ← i.
- No accept: mul_din_valid ← 0; mul_din1/2 hold their values.
- Tag pipeline: MUL_LAT entries of {valid, id}. The head is loaded from {mul_din_valid, issue id}. The entries shift every cycle, unconditionally.
- At the tail, when mul_dout_valid = 1 and tail.valid = 1:
  - rsp_valid ← one-hot(tail.id); rsp_dout ← mul_dout.
  - Otherwise rsp_valid ← 0 and rsp_dout holds.
- Responses cannot be refused. Requesters sink rsp_valid whenever it fires.
- err is set when mul_dout_valid ≠ tail.valid. It is cleared only by reset. The response on that cycle is suppressed.
- busy = mul_din_valid | OR of all tag valids.
- en = 0 mid-stream: no new grants. Operations already issued complete normally and busy falls after MUL_LAT+1 cycles.

## Timing
- Accept at cycle t:
  - mul_din_valid at t+1.
  - mul_dout_valid at t+1+MUL_LAT.
  - rsp_valid at t+2+MUL_LAT. Total latency is MUL_LAT+2 (16 with defaults).
- Throughput: one accept per cycle. With all N requesters valid continuously, each is granted exactly once every N cycles.
- Reset values:
  - last = N−1, so ID 0 has first priority.
  - req_ready combinational from reset state.
  - mul_din_valid = 0, mul_din1/2 = 0.
  - All tag entries invalid, rsp_valid = 0, rsp_dout = 0.
  - busy = 0, err = 0, stat_cnt = 0.
- Reset asserted mid-operation discards every in-flight tag. Products arriving after reset release, with no matching tag, set err. The integrator resets the multiplier together with this block.
- Single requester valid: it is granted every cycle, and the pointer follows it.

## Configuration
- MUL_ARB_STATS_EN defined:
  - stat_cnt[i·16 +: 16] increments on each accept of requester i and saturates at 16'hFFFF.
  - Reset value 0.
- Undefined: stat_cnt is constant 0 and no counter flops are built.

## Test plan
- Reset, then req_valid = 4'b0001, din1 = 3, din2 = −5 (two's complement), with a behavioural MUL_LAT = 14 multiplier model → req_ready = 0001 at once, mul_din_valid 1 cycle later, rsp_valid = 0001 with rsp_dout = −15 (sign-extended to 52 bits) 16 cycles after accept.
- All four requesters valid for 8 cycles → grant order 0,1,2,3,0,1,2,3. Responses return in the same order, back-to-back, each with the correct product.
- req_valid = 1010 held continuously, starting from last = N−1 → grants alternate 1,3,1,3, and requesters 0 and 2 are never granted.
- Issue 3 ops, then drop en for 20 cycles → no further req_ready. All 3 responses arrive. busy deasserts exactly MUL_LAT+1 cycles after the last issue.
- Model injects a spurious mul_dout_valid with an empty pipeline → err = 1 next cycle, no rsp_valid, err stays high until nrst.
- With MUL_ARB_STATS_EN, requester 2 issues 70000 ops → stat_cnt for requester 2 saturates at 65535, others stay 0. Without the macro, stat_cnt = 0 throughout.
